// File: rtl/sid_pkg.sv
// sid_pkg: shared opcode, FSM state and command encodings for the SID bus sequencer
package sid_pkg;
   localparam logic [1:0] OP_WRITE = 2'b00;
   localparam logic [1:0] OP_READ  = 2'b01;
   localparam logic [1:0] OP_WAIT  = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_READ  = 3'd2;
   localparam logic [2:0] S_RCAP  = 3'd3;
   localparam logic [2:0] S_RESP  = 3'd4;
   localparam logic [2:0] S_WAIT  = 3'd5;
   typedef struct packed {
      logic [1:0] op;
      logic [5:0] addr;
      logic [7:0] data;
   } cmd_t;
endpackage

// File: rtl/sid_cmd_fifo.sv
// sid_cmd_fifo: show-ahead command FIFO with occupancy count, power-of-two depth
module sid_cmd_fifo #(
   parameter int W = 16,
   parameter int D = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 push,
   input  logic                 pop,
   input  logic [W-1:0]         din,
   output logic [W-1:0]         dout,
   output logic [$clog2(D):0]   count
);
   localparam int AW = $clog2(D);
   logic [W-1:0] r_mem [D];
   logic [AW-1:0] r_wr, r_rd;
   logic [AW:0] r_cnt;
   logic w_push, w_pop;
   assign w_push = push && r_cnt != (AW+1)'(D);
   assign w_pop  = pop && r_cnt != '0;
   assign dout   = r_mem[r_rd];
   assign count  = r_cnt;
   // storage needs no reset: the count decides which entries are live
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= din;
   end
   // pointers wrap naturally at the power-of-two depth; push+pop keeps the count
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
endmodule

// File: rtl/sid_bus_sequencer.sv
// sid_bus_sequencer: queues host commands and plays them onto the SID register bus
module sid_bus_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int TICK_DIV   = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [5:0] cmd_addr,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   input  logic       rsp_ready,
   output logic [5:0] sid_addr,
   output logic [7:0] sid_wdata,
   input  logic [7:0] sid_rdata,
   output logic       sid_cyc,
   output logic       sid_we,
   output logic       busy,
   output logic       bad_op
);
   import sid_pkg::*;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(255 * TICK_DIV + 1);
   logic [AW:0] w_count;
   logic w_full, w_empty, w_push, w_pop;
   cmd_t w_cmd;
   logic [CW-1:0] w_wait_load, r_cnt;
   logic [2:0] r_state;
   logic [5:0] r_addr;
   logic [7:0] r_wdata, r_rdata;
   logic r_bad;
   assign w_full      = w_count == (AW+1)'(FIFO_DEPTH);
   assign w_empty     = w_count == '0;
   assign w_push      = cmd_valid && !w_full;
   assign w_pop       = r_state == S_IDLE && !w_empty;
   assign w_wait_load = CW'(w_cmd.data) * CW'(TICK_DIV) - CW'(1);
   sid_cmd_fifo #(.W($bits(cmd_t)), .D(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (w_push),
      .pop   (w_pop),
      .din   ({cmd_op, cmd_addr, cmd_data}),
      .dout  (w_cmd),
      .count (w_count)
   );
   assign cmd_ready = !w_full;
   assign sid_cyc   = r_state == S_WRITE || r_state == S_READ;
   assign sid_we    = r_state == S_WRITE;
   assign sid_addr  = r_addr;
   assign sid_wdata = r_wdata;
   assign rsp_valid = r_state == S_RESP;
   assign rsp_data  = r_rdata;
   assign busy      = !w_empty || r_state != S_IDLE;
   assign bad_op    = r_bad;
   // sequencer: dispatch from IDLE, one-cycle bus strobes, read capture, response hold, tick wait
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_bad   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (!w_empty) begin
               case (w_cmd.op)
                  OP_WRITE: begin
                     r_addr  <= w_cmd.addr;
                     r_wdata <= w_cmd.data;
                     r_state <= S_WRITE;
                  end
                  OP_READ: begin
                     r_addr  <= w_cmd.addr;
                     r_state <= S_READ;
                  end
                  OP_WAIT: if (w_cmd.data != '0) begin
                     r_cnt   <= w_wait_load;
                     r_state <= S_WAIT;
                  end
                  default: r_bad <= 1'b1;
               endcase
            end
            S_WRITE: r_state <= S_IDLE;
            S_READ:  r_state <= S_RCAP;
            S_RCAP: begin
               r_rdata <= sid_rdata;
               r_state <= S_RESP;
            end
            S_RESP: if (rsp_ready) r_state <= S_IDLE;
            S_WAIT: if (r_cnt == '0) r_state <= S_IDLE; else r_cnt <= r_cnt - CW'(1);
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sid_bus_sequencer.sv
// tb_sid_bus_sequencer: random and directed command streams checked against an in-order command model
module tb_sid_bus_sequencer;
   localparam int TD = 16;
   logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
   logic [1:0] cmd_op = '0;
   logic [5:0] cmd_addr = '0;
   logic [7:0] cmd_data = '0;
   logic [7:0] sid_rdata;
   logic cmd_ready, rsp_valid, sid_cyc, sid_we, busy, bad_op;
   logic [7:0] rsp_data, sid_wdata;
   logic [5:0] sid_addr;

   always #5 clk = ~clk;

   sid_bus_sequencer #(.FIFO_DEPTH(4), .TICK_DIV(TD)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
      .sid_addr(sid_addr), .sid_wdata(sid_wdata), .sid_rdata(sid_rdata),
      .sid_cyc(sid_cyc), .sid_we(sid_we), .busy(busy), .bad_op(bad_op)
   );

   function automatic logic [7:0] init_val(input int a);
      return a == 27 ? 8'hA5 : 8'(a * 37 + 11);
   endfunction

   // SID register file: written on write strobes, read data registered one clock after the strobe
   logic [7:0] sid_mem [64];
   logic [63:0] sid_wr_mask = '0;
   always @(posedge clk) begin
      if (sid_cyc && sid_we) begin
         sid_mem[sid_addr] <= sid_wdata;
         sid_wr_mask[sid_addr] <= 1'b1;
      end
      if (sid_cyc && !sid_we)
         sid_rdata <= sid_wr_mask[sid_addr] ? sid_mem[sid_addr] : init_val(int'(sid_addr));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // bus/response observer sampled mid-cycle
   logic [13:0] wr_q[$];
   int wr_cyc_q[$];
   logic [7:0] rsp_q[$];
   int rd_cyc = 0, n_cyc = 0, n_long = 0;
   logic prev_cyc = 1'b0;
   always @(negedge clk) begin
      if (sid_cyc) n_cyc++;
      if (sid_cyc && prev_cyc) n_long++;
      prev_cyc = sid_cyc;
      if (sid_cyc && sid_we) begin
         wr_q.push_back({sid_addr, sid_wdata});
         wr_cyc_q.push_back(cyc);
      end
      if (sid_cyc && !sid_we) rd_cyc = cyc;
      if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
   end

   // reference model: commands execute strictly in order against a flat register image
   logic [7:0] model_mem [64];
   logic [13:0] exp_wr[$];
   logic [7:0] exp_rsp[$];
   int exp_cyc = 0, wb = 0, rb = 0, cb = 0;
   logic exp_bad = 1'b0, rnd_rdy = 1'b0;
   int n_chk = 0, n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (rnd_rdy) rsp_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic push(input logic [1:0] op, input logic [5:0] a, input logic [7:0] d, output int edge_at);
      int k = 0;
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_addr = a;
      cmd_data = d;
      while (!cmd_ready && k < 2000) begin
         tick();
         k++;
      end
      check("push_ready", cmd_ready, 1);
      tick();
      edge_at = cyc;
      cmd_valid = 1'b0;
      if (op == 2'b00) begin
         exp_wr.push_back({a, d});
         model_mem[a] = d;
         exp_cyc++;
      end else if (op == 2'b01) begin
         exp_rsp.push_back(model_mem[a]);
         exp_cyc++;
      end else if (op == 2'b11) exp_bad = 1'b1;
   endtask

   task automatic drain();
      int k = 0;
      if (!rnd_rdy) rsp_ready = 1'b1;
      while (busy && k < 5000) begin
         tick();
         k++;
      end
      check("drain_busy", busy, 0);
   endtask

   task automatic compare(input string sec);
      check({sec, "_nwr"}, 32'(wr_q.size() - wb), 32'(exp_wr.size()));
      for (int i = 0; i < exp_wr.size(); i++)
         if (wb + i < wr_q.size()) check({sec, "_wr"}, 32'(wr_q[wb + i]), 32'(exp_wr[i]));
      check({sec, "_nrsp"}, 32'(rsp_q.size() - rb), 32'(exp_rsp.size()));
      for (int i = 0; i < exp_rsp.size(); i++)
         if (rb + i < rsp_q.size()) check({sec, "_rsp"}, 32'(rsp_q[rb + i]), 32'(exp_rsp[i]));
      check({sec, "_ncyc"}, 32'(n_cyc - cb), 32'(exp_cyc));
      wb = wr_q.size();
      rb = rsp_q.size();
      cb = n_cyc;
      exp_wr.delete();
      exp_rsp.delete();
      exp_cyc = 0;
   endtask

   initial begin
      int e, ew, k, r;
      logic [1:0] op;
      logic [7:0] d;
      logic [7:0] save_mem [64];
      for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
      repeat (3) tick();
      check("rst_cmd_ready", cmd_ready, 1);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_data", rsp_data, 0);
      check("rst_sid_cyc", sid_cyc, 0);
      check("rst_sid_we", sid_we, 0);
      check("rst_sid_addr", sid_addr, 0);
      check("rst_sid_wdata", sid_wdata, 0);
      check("rst_busy", busy, 0);
      check("rst_bad_op", bad_op, 0);
      rst_n = 1'b1;
      tick();

      push(2'b00, 6'd24, 8'h0F, e);
      drain();
      check("wr_lat", (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - e : -1, 1);
      compare("w24");

      rsp_ready = 1'b0;
      push(2'b01, 6'd27, 8'h00, e);
      k = 0;
      while (!rsp_valid && k < 100) begin
         tick();
         k++;
      end
      check("rd_lat", cyc - rd_cyc, 2);
      check("rd_data", rsp_data, 8'hA5);
      repeat (3) begin
         tick();
         check("hold_valid", rsp_valid, 1);
         check("hold_data", rsp_data, 8'hA5);
      end
      rsp_ready = 1'b1;
      tick();
      check("rsp_drop", rsp_valid, 0);
      drain();
      compare("rd27");

      push(2'b10, 6'd0, 8'd3, ew);
      for (int i = 0; i < 4; i++) push(2'b00, 6'(1 + i), 8'(8'h10 + i), e);
      check("full_ready", cmd_ready, 0);
      push(2'b00, 6'd5, 8'h14, e);
      drain();
      check("wait3_len", (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - ew : -1, 3 * TD + 2);
      compare("wait3");

      push(2'b10, 6'd0, 8'd0, ew);
      push(2'b00, 6'd33, 8'h5C, e);
      drain();
      check("wait0_lat", (wr_cyc_q.size() > wb) ? wr_cyc_q[wb] - ew : -1, 2);
      compare("wait0");

      check("bad_clear", bad_op, 0);
      push(2'b11, 6'd5, 8'h09, e);
      push(2'b00, 6'd10, 8'h33, e);
      drain();
      check("bad_set", bad_op, 1);
      compare("rsvd");

      rnd_rdy = 1'b1;
      repeat (80) begin
         r = $urandom_range(0, 15);
         op = r < 7 ? 2'b00 : r < 13 ? 2'b01 : r < 15 ? 2'b10 : 2'b11;
         d = op == 2'b10 ? 8'($urandom_range(0, 1)) : 8'($urandom);
         push(op, 6'($urandom), d, e);
         repeat ($urandom_range(0, 2)) tick();
      end
      drain();
      check("rand_bad", bad_op, 32'(exp_bad));
      compare("rand");
      rnd_rdy = 1'b0;

      save_mem = model_mem;
      rsp_ready = 1'b0;
      push(2'b01, 6'd40, 8'h00, e);
      k = 0;
      while (!rsp_valid && k < 100) begin
         tick();
         k++;
      end
      for (int i = 0; i < 3; i++) push(2'b00, 6'(50 + i), 8'(8'hC0 + i), e);
      check("resp_held", rsp_valid, 1);
      rst_n = 1'b0;
      tick();
      check("rr_rsp_valid", rsp_valid, 0);
      check("rr_busy", busy, 0);
      check("rr_cmd_ready", cmd_ready, 1);
      check("rr_bad_op", bad_op, 0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      wb = wr_q.size();
      rb = rsp_q.size();
      cb = n_cyc;
      repeat (10) tick();
      check("rr_no_wr", 32'(wr_q.size() - wb), 0);
      check("rr_no_rsp", 32'(rsp_q.size() - rb), 0);
      check("rr_no_cyc", 32'(n_cyc - cb), 0);
      model_mem = save_mem;
      exp_wr.delete();
      exp_rsp.delete();
      exp_cyc = 0;

      push(2'b10, 6'd0, 8'd2, e);
      push(2'b00, 6'd60, 8'h77, e);
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      wb = wr_q.size();
      cb = n_cyc;
      repeat (2 * TD + 10) tick();
      check("rw_no_cyc", 32'(n_cyc - cb), 0);
      check("rw_busy", busy, 0);

      check("cyc_width", n_long, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/sid_bus_sequencer.md
SID_BUS_SEQUENCER -- requirements
Module: sid_bus_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: command FIFO entries (power of two).
REQ-002 SHALL have parameter TICK_DIV, default 16: clocks per WAIT unit.
REQ-003 SHALL have port clk, input, 1: sole clock; all logic samples on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid, input, 1: host command present.
REQ-006 SHALL have port cmd_ready, output, 1: FIFO can accept a command.
REQ-007 SHALL have port cmd_op, input, 2: 00 WRITE, 01 READ, 10 WAIT, 11 reserved.
REQ-008 SHALL have port cmd_addr, input, 6: SID register address.
REQ-009 SHALL have port cmd_data, input, 8: write data, or WAIT count.
REQ-010 SHALL have port rsp_valid, output, 1: read data available.
REQ-011 SHALL have port rsp_data, output, 8: read data.
REQ-012 SHALL have port rsp_ready, input, 1: host accepts the response.
REQ-013 SHALL have port sid_addr, output, 6: to SID addr.
REQ-014 SHALL have port sid_wdata, output, 8: to SID bus_in.
REQ-015 SHALL have port sid_rdata, input, 8: from SID bus_out, registered by the SID one clock after cyc.
REQ-016 SHALL have port sid_cyc, output, 1: bus cycle strobe.
REQ-017 SHALL have port sid_we, output, 1: write qualifier.
REQ-018 SHALL have port busy, output, 1: FIFO non-empty or state not IDLE.
REQ-019 SHALL have port bad_op, output, 1: sticky flag, reserved opcode seen.

Function
REQ-020 SHALL push {op,addr,data} when cmd_valid&&cmd_ready; cmd_ready = !full, registered-free combinational from the FIFO count.
REQ-021 SHALL pop and issue from IDLE only, no earlier than one cycle after the push.
REQ-022 SHALL use FSM states IDLE, WRITE, READ, RCAP, RESP and WAIT; an illegal state SHALL recover to IDLE.
REQ-023 In WRITE, SHALL drive sid_cyc=1, sid_we=1 for exactly one cycle; WRITE->IDLE allows a write every two cycles.
REQ-024 In READ, SHALL drive sid_cyc=1, sid_we=0 for one cycle; RCAP follows and latches sid_rdata into rsp_data at the end of RCAP.
REQ-025 In RESP, SHALL hold rsp_valid=1 and rsp_data stable until rsp_ready; accept -> IDLE; no FIFO pop while in RESP.
REQ-026 Read latency from the READ cycle to rsp_valid SHALL be exactly 2 clocks.
REQ-027 WAIT with count n SHALL stall n*TICK_DIV clocks, using a counter of width clog2(255*TICK_DIV+1); n=0 SHALL cost one cycle.
REQ-028 Opcode 11 SHALL be popped and discarded in one cycle, setting bad_op; bad_op clears only on reset.
REQ-029 sid_cyc/sid_we SHALL be 0 outside WRITE/READ; sid_addr/sid_wdata SHALL be registered and hold the last issued values.
REQ-030 A push and a pop in the same cycle SHALL leave the count unchanged; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 On rst_n=0 at a clock edge: FIFO flushed (count 0), state IDLE, cmd_ready=1, rsp_valid=0, rsp_data=0, sid_cyc=0, sid_we=0, sid_addr=0, sid_wdata=0, busy=0, bad_op=0.
REQ-032 Reset mid-read or mid-wait SHALL abort; no response emitted afterward.

Structure
REQ-033 Opcode encodings and FSM state encodings SHALL live in a shared package (sid_pkg).
REQ-034 The FIFO SHALL be a sub-module, sid_cmd_fifo (parameterised width/depth, count output).

Verification
REQ-035 WRITE addr 24 data 0x0F -> one cycle of sid_cyc=1, sid_we=1 with sid_addr=24, sid_wdata=0x0F.
REQ-036 READ addr 27 with the SID model returning 0xA5 -> rsp_valid 2 clocks after the READ cycle, rsp_data=0xA5, held through 3 cycles of rsp_ready=0.
REQ-037 5 pushes with no drain and TICK_DIV=16, WAIT 3 queued first -> cmd_ready low after 4 entries; the WAIT lasts 48 clocks; all writes then issue in order.
REQ-038 WAIT 0 followed by a WRITE -> the write issues 2 cycles after the WAIT pop.
REQ-039 Opcode 11 -> bad_op=1, no sid_cyc; the next command executes normally.
REQ-040 rst_n=0 asserted during RESP with 3 entries queued -> rsp_valid=0, busy=0, cmd_ready=1 the next cycle.
